divisor_secuencial_param: RTL and testbench

Parametrised sequential radix-2 restoring divider for signed or unsigned operands, selected per operation. It is the next-generation divider of the arithmetic block set: WIDTH is generic, Start/Busy/Done handshake with back-to-back issue, registered results with status flags, and optional early divide-by-zero exit. It sits between the operand registers and the result bus of the datapath.

---
 rtl/divisor_pkg.sv | 23 ++
 rtl/divisor_signo.sv | 20 ++
 rtl/divisor_secuencial_param.sv | 146 ++++++++++++++
 tb/tb_divisor_secuencial_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// divisor_pkg: shared types and helpers for the sequential radix-2 restoring divider.
// Holds the FSM state type, the WIDTH legality bounds and the conditional negate.
package divisor_pkg;

    // Legal range for the operand/result width.
    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    // Works on the widest legal operand; callers keep only their low bits.
    function automatic logic [WIDTH_MAX-1:0] neg_cond(input logic [WIDTH_MAX-1:0] v,
                                                      input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/divisor_signo.sv
// divisor_signo: combinational magnitude / sign-restore unit.
// Used on the way in (|Num|, |Den|) and on the way out (signed quotient/remainder).
module divisor_signo
    import divisor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    // Full-width result of the shared helper; bits above WIDTH are discarded.
    logic [WIDTH_MAX-1:0] wide_unused;

    // Negate at maximum width, then truncate back to the operand width.
    assign wide_unused = neg_cond(WIDTH_MAX'(val), neg);
    assign res         = wide_unused[WIDTH-1:0];

endmodule

// File: rtl/divisor_secuencial_param.sv
// divisor_secuencial_param: sequential radix-2 restoring divider, signed or unsigned
// per operation, Start/Busy/Done handshake with back-to-back issue.
// Optional feature: define DIVISOR_DIVZERO_EN to skip the iteration when Den==0
// (result all ones / Num, DivZero flagged, Done two cycles after Start).
module divisor_secuencial_param
    import divisor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RSTa,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Num,
    input  logic [WIDTH-1:0] Den,
    output logic [WIDTH-1:0] Coc,
    output logic [WIDTH-1:0] Res,
    output logic             Done,
    output logic             Busy,
    output logic             DivZero,
    output logic             Overflow
);

    localparam int               CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_bad
        $error("divisor_secuencial_param: WIDTH out of legal range");
    end

    state_t state, state_nxt;

    // Datapath registers: ACC carries one extra bit so the shifted-out bit survives the compare.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;
    logic             s_num, s_den;
    logic             dz_pend, ovf_pend;

    logic             num_neg, den_neg, den_zero;
    logic [WIDTH-1:0] num_mag, den_mag, coc_fix, res_fix;
    logic [WIDTH:0]   acc_sh;
    logic             take;

    assign num_neg = Signed & Num[WIDTH-1];
    assign den_neg = Signed & Den[WIDTH-1];

`ifdef DIVISOR_DIVZERO_EN
    assign den_zero = (Den == '0);
`else
    assign den_zero = 1'b0;
`endif

    // Operand magnitudes; MIN maps to the unsigned value 2^(WIDTH-1).
    divisor_signo #(.WIDTH(WIDTH)) u_num_mag (.val(Num), .neg(num_neg), .res(num_mag));
    divisor_signo #(.WIDTH(WIDTH)) u_den_mag (.val(Den), .neg(den_neg), .res(den_mag));

    // Sign restore: quotient truncates toward zero, remainder takes the dividend sign.
    divisor_signo #(.WIDTH(WIDTH)) u_coc_sgn (.val(q), .neg(s_num ^ s_den), .res(coc_fix));
    divisor_signo #(.WIDTH(WIDTH)) u_res_sgn (.val(acc[WIDTH-1:0]), .neg(s_num), .res(res_fix));

    // One restoring step: shift {ACC,Q} left and try to subtract the divisor magnitude.
    assign acc_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign take   = (acc_sh >= {1'b0, m});

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; Start is honoured in IDLE and in the DONE cycle only.
    // NOTE: the default assignment at the top of a combinational block prevents latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = den_zero ? FIX : CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = Start ? (den_zero ? FIX : CALC) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        Busy = (state == CALC) || (state == FIX);
        Done = (state == DONE);
    end

    // Datapath: operand load, iteration, and result/flag registration in FIX.
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            cnt      <= '0;
            s_num    <= 1'b0;
            s_den    <= 1'b0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
            Coc      <= '0;
            Res      <= '0;
            DivZero  <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        cnt      <= CW'(WIDTH - 1);
                        m        <= den_mag;
                        dz_pend  <= den_zero;
                        ovf_pend <= Signed && (Num == MIN_VAL) && (Den == '1);
                        if (den_zero) begin
                            // Preload the divide-by-zero answer so FIX passes it through unsigned.
                            q     <= '1;
                            acc   <= {1'b0, Num};
                            s_num <= 1'b0;
                            s_den <= 1'b0;
                        end else begin
                            q     <= num_mag;
                            acc   <= '0;
                            s_num <= num_neg;
                            s_den <= den_neg;
                        end
                    end
                end
                CALC: begin
                    acc <= take ? (acc_sh - {1'b0, m}) : acc_sh;
                    q   <= {q[WIDTH-2:0], take};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    Coc      <= coc_fix;
                    Res      <= res_fix;
                    DivZero  <= dz_pend;
                    Overflow <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial_param.sv
// tb_divisor_secuencial_param: self-checking bench for divisor_secuencial_param at
// WIDTH=32 and WIDTH=8. Expected results come from integer division in a reference
// model; latency is measured in cycles from the Start cycle to the Done cycle.
module tb_divisor_secuencial_param;

`ifdef DIVISOR_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    typedef enum int {O_COC, O_RES, O_DONE, O_BUSY, O_DZ, O_OVF} out_e;

    logic        CLK = 1'b0;
    logic        RSTa;

    logic        st32, sg32;
    logic [31:0] num32, den32, coc32, res32;
    logic        done32, busy32, dz32, ovf32;

    logic        st8, sg8;
    logic [7:0]  num8, den8, coc8, res8;
    logic        done8, busy8, dz8, ovf8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done32_log[$];
    int done8_log[$];

    divisor_secuencial_param #(.WIDTH(32)) dut32 (
        .CLK(CLK), .RSTa(RSTa), .Start(st32), .Signed(sg32), .Num(num32), .Den(den32),
        .Coc(coc32), .Res(res32), .Done(done32), .Busy(busy32), .DivZero(dz32), .Overflow(ovf32)
    );

    divisor_secuencial_param #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RSTa(RSTa), .Start(st8), .Signed(sg8), .Num(num8), .Den(den8),
        .Coc(coc8), .Res(res8), .Done(done8), .Busy(busy8), .DivZero(dz8), .Overflow(ovf8)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log the cycle number of every Done pulse for count/spacing checks.
    always @(negedge CLK) begin
        if (done32 === 1'b1) done32_log.push_back(cyc);
        if (done8 === 1'b1)  done8_log.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: plain integer division, truncation toward zero, remainder follows dividend.
    function automatic void model(input int w, input logic sg, input logic [63:0] n_in,
                                  input logic [63:0] d_in, output logic [63:0] q,
                                  output logic [63:0] r, output logic ovf, output logic dz);
        logic [63:0] m = mask_of(w);
        logic [63:0] n = n_in & m;
        logic [63:0] d = d_in & m;
        longint a, b;
        ovf = 1'b0;
        dz  = 1'b0;
        if (d == 0) begin
            q  = m;
            r  = n;
            dz = DZ_EN;
        end else if (sg) begin
            a   = longint'(n << (64 - w)) >>> (64 - w);
            b   = longint'(d << (64 - w)) >>> (64 - w);
            q   = 64'(a / b) & m;
            r   = 64'(a % b) & m;
            ovf = (n == (64'd1 << (w - 1))) && (d == m);
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    function automatic logic [63:0] out_of(input int w, input out_e o);
        logic [63:0] v;
        v = '0;
        case (o)
            O_COC:  v = (w == 32) ? 64'(coc32)  : 64'(coc8);
            O_RES:  v = (w == 32) ? 64'(res32)  : 64'(res8);
            O_DONE: v = (w == 32) ? 64'(done32) : 64'(done8);
            O_BUSY: v = (w == 32) ? 64'(busy32) : 64'(busy8);
            O_DZ:   v = (w == 32) ? 64'(dz32)   : 64'(dz8);
            O_OVF:  v = (w == 32) ? 64'(ovf32)  : 64'(ovf8);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic drive(input int w, input logic st, input logic sg,
                         input logic [63:0] n, input logic [63:0] d);
        if (w == 32) begin
            st32 = st; sg32 = sg; num32 = n[31:0]; den32 = d[31:0];
        end else begin
            st8 = st; sg8 = sg; num8 = n[7:0]; den8 = d[7:0];
        end
    endtask

    task automatic check_all_zero(input int w, input string tag);
        string names[6] = '{"coc", "res", "done", "busy", "divzero", "overflow"};
        for (int i = 0; i < 6; i++)
            check($sformatf("%s.%s", tag, names[i]), out_of(w, out_e'(i)), 64'd0);
    endtask

    // Issue one operation (call either between edges or in a Done cycle for back-to-back)
    // and check latency, results and flags. With junk set, extra Start pulses with random
    // operands are injected while the operation is busy.
    task automatic do_op(input int w, input logic sg, input logic [63:0] n,
                         input logic [63:0] d, input string tag, input bit junk);
        logic [63:0] eq, er;
        logic        eo, ez;
        int          e, lat, exp_lat;
        model(w, sg, n, d, eq, er, eo, ez);
        exp_lat = (DZ_EN && ((d & mask_of(w)) == 0)) ? 2 : w + 2;
        drive(w, 1'b1, sg, n, d);
        @(posedge CLK); #1;
        drive(w, 1'b0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        check({tag, ".busy"}, out_of(w, O_BUSY), 64'd1);
        e = 0;
        while (out_of(w, O_DONE) != 64'd1 && e < 200) begin
            drive(w, junk && (e == 5 || e == 15), 1'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom});
            @(posedge CLK); #1;
            e++;
        end
        drive(w, 1'b0, 1'b0, '0, '0);
        lat = e + 1;
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".coc"}, out_of(w, O_COC), eq);
        check({tag, ".res"}, out_of(w, O_RES), er);
        check({tag, ".overflow"}, out_of(w, O_OVF), 64'(eo));
        check({tag, ".divzero"}, out_of(w, O_DZ), 64'(ez));
    endtask

    // One cycle after a Done with no new Start: Done must have dropped, nothing busy.
    task automatic idle_check(input int w, input string tag);
        @(posedge CLK); #1;
        check({tag, ".done_pulse"}, out_of(w, O_DONE), 64'd0);
        check({tag, ".idle_busy"}, out_of(w, O_BUSY), 64'd0);
    endtask

    // Abort an operation with RSTa in CALC cycle k; no Done may follow.
    task automatic reset_mid(input int w, input int k, input string tag);
        int n0, n1;
        drive(w, 1'b1, 1'b0, 64'd1000, 64'd3);
        @(posedge CLK); #1;
        drive(w, 1'b0, 1'b0, '0, '0);
        repeat (k - 1) @(posedge CLK);
        #1;
        n0 = (w == 32) ? done32_log.size() : done8_log.size();
        RSTa = 1'b1;
        #1;
        check_all_zero(w, tag);
        @(negedge CLK);
        RSTa = 1'b0;
        @(posedge CLK); #1;
        check({tag, ".first_edge_idle"}, out_of(w, O_BUSY), 64'd0);
        repeat (2 * w + 4) @(posedge CLK);
        #1;
        n1 = (w == 32) ? done32_log.size() : done8_log.size();
        check({tag, ".no_done"}, 64'(n1), 64'(n0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n0, sp;
        logic        sg;
        logic [63:0] n, d;
        int          tmp;

        RSTa = 1'b1;
        drive(32, 1'b0, 1'b0, '0, '0);
        drive(8, 1'b0, 1'b0, '0, '0);
        #12;
        check_all_zero(32, "reset32");
        check_all_zero(8, "reset8");
        @(negedge CLK);
        RSTa = 1'b0;
        @(negedge CLK);

        // Directed WIDTH=32 cases.
        do_op(32, 1'b0, 64'd100, 64'd7, "u100_7", 1'b0);
        check("u100_7.coc_const", out_of(32, O_COC), 64'd14);
        check("u100_7.res_const", out_of(32, O_RES), 64'd2);
        idle_check(32, "u100_7");
        do_op(32, 1'b1, 64'(-7), 64'd2, "s-7_2", 1'b0);
        check("s-7_2.coc_const", out_of(32, O_COC), 64'hFFFF_FFFD);
        check("s-7_2.res_const", out_of(32, O_RES), 64'hFFFF_FFFF);
        idle_check(32, "s-7_2");
        do_op(32, 1'b1, 64'd7, 64'(-2), "s7_-2", 1'b0);
        idle_check(32, "s7_-2");
        do_op(32, 1'b1, 64'(-7), 64'(-2), "s-7_-2", 1'b0);
        idle_check(32, "s-7_-2");
        do_op(32, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "s_min_-1", 1'b0);
        check("s_min_-1.overflow_const", out_of(32, O_OVF), 64'd1);
        idle_check(32, "s_min_-1");
        do_op(32, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, "u_min_max", 1'b0);
        idle_check(32, "u_min_max");
`ifdef DIVISOR_DIVZERO_EN
        do_op(32, 1'b0, 64'd55, 64'd0, "dz55", 1'b0);
        check("dz55.coc_const", out_of(32, O_COC), 64'hFFFF_FFFF);
        idle_check(32, "dz55");
`endif

        // Random WIDTH=32 operations.
        for (int i = 0; i < 8; i++) begin
            sg = 1'($urandom);
            n  = {32'd0, $urandom};
            if (i % 3 == 0) begin
                tmp = int'($urandom_range(1, 20));
                d   = (sg && i % 2 == 0) ? 64'(-tmp) : 64'(tmp);
            end else begin
                d = {32'd0, $urandom >> $urandom_range(0, 28)};
            end
            if ((d & mask_of(32)) == 0) d = 64'd1;
            do_op(32, sg, n, d, $sformatf("rnd32_%0d", i), 1'b0);
            idle_check(32, $sformatf("rnd32_%0d", i));
        end

        // Back-to-back: each Start lands in the previous Done cycle; busy-time Starts ignored.
        n0 = done32_log.size();
        do_op(32, 1'b0, 64'd1000, 64'd3, "b2b0", 1'b1);
        do_op(32, 1'b1, 64'(-50), 64'd7, "b2b1", 1'b1);
        do_op(32, 1'b0, 64'hFFFF_FFFF, 64'd16, "b2b2", 1'b1);
        idle_check(32, "b2b2");
        check("b2b.done_count", 64'(done32_log.size() - n0), 64'd3);
        sp = done32_log[n0 + 1] - done32_log[n0];
        check("b2b.spacing01", 64'(sp), 64'd34);
        sp = done32_log[n0 + 2] - done32_log[n0 + 1];
        check("b2b.spacing12", 64'(sp), 64'd34);

        // Abort at CALC cycle 10, then a fresh operation must complete correctly.
        reset_mid(32, 10, "abort32");
        do_op(32, 1'b1, 64'(-1234567), 64'd1000, "after_abort32", 1'b0);
        idle_check(32, "after_abort32");

        // WIDTH=8 instance.
        do_op(8, 1'b0, 64'd100, 64'd7, "w8_u100_7", 1'b0);
        idle_check(8, "w8_u100_7");
        do_op(8, 1'b1, 64'(-7), 64'd2, "w8_s-7_2", 1'b0);
        idle_check(8, "w8_s-7_2");
        do_op(8, 1'b1, 64'h80, 64'hFF, "w8_s_min_-1", 1'b0);
        idle_check(8, "w8_s_min_-1");
        do_op(8, 1'b0, 64'h80, 64'hFF, "w8_u_min_max", 1'b0);
        idle_check(8, "w8_u_min_max");
        for (int i = 0; i < 6; i++) begin
            sg = 1'($urandom);
            n  = 64'($urandom_range(0, 255));
            d  = 64'($urandom_range(1, 255));
            do_op(8, sg, n, d, $sformatf("rnd8_%0d", i), 1'b0);
            idle_check(8, $sformatf("rnd8_%0d", i));
        end
        reset_mid(8, 5, "abort8");
        do_op(8, 1'b1, 64'd7, 64'(-2), "after_abort8", 1'b0);
        idle_check(8, "after_abort8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
